// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: hunts for a header, then decodes write, read and start frames.
// Bursts use an optional length byte; an inter-byte timeout and bad bytes raise err_pulse.
module uart_cmd_parser #(
  parameter logic [7:0] HEADER       = 8'h23,
  parameter logic [7:0] CMD_WR       = 8'h09,
  parameter logic [7:0] CMD_RD       = 8'h04,
  parameter logic [7:0] CMD_START    = 8'h14,
  parameter int         ADDR_BYTES   = 2,
  parameter int         DATA_BYTES   = 1,
  parameter int         LEN_EN       = 1,
  parameter int         TIMEOUT_CLKS = 4096,
  localparam int        AW           = 8 * ADDR_BYTES,
  localparam int        DW           = 8 * DATA_BYTES
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_ack,
  output logic          start_pulse,
  output logic          err_pulse,
  output logic [1:0]    err_code,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, LEN, DATA, RD_ISSUE} state_t;

  state_t        state_reg, state_next;
  logic          is_rd_reg, is_rd_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] word_reg, word_next;
  logic [7:0]    count_reg, count_next;
  logic [7:0]    byte_cnt_reg, byte_cnt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          wr_en_reg, wr_en_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic [DW-1:0] wr_data_reg, wr_data_next;
  logic          rd_req_reg, rd_req_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_next;
  logic          start_reg, start_next;
  logic          err_reg, err_next;
  logic [1:0]    err_code_reg, err_code_next;
  logic          busy_reg, busy_next;
  logic          timed_out;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      is_rd_reg    <= 1'b0;
      addr_reg     <= '0;
      word_reg     <= '0;
      count_reg    <= '0;
      byte_cnt_reg <= '0;
      timer_reg    <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      rd_req_reg   <= 1'b0;
      rd_addr_reg  <= '0;
      start_reg    <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      is_rd_reg    <= is_rd_next;
      addr_reg     <= addr_next;
      word_reg     <= word_next;
      count_reg    <= count_next;
      byte_cnt_reg <= byte_cnt_next;
      timer_reg    <= timer_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      rd_req_reg   <= rd_req_next;
      rd_addr_reg  <= rd_addr_next;
      start_reg    <= start_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    is_rd_next    = is_rd_reg;
    addr_next     = addr_reg;
    word_next     = word_reg;
    count_next    = count_reg;
    byte_cnt_next = byte_cnt_reg;
    timer_next    = '0;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    rd_req_next   = rd_req_reg;
    rd_addr_next  = rd_addr_reg;
    start_next    = 1'b0;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    timed_out     = 1'b0;

    // A byte arriving on the limit cycle takes priority over the timeout.
    if (state_reg inside {CMD, ADDR, LEN, DATA}) begin
      if (rx_valid)
        timer_next = '0;
      else if (timer_reg == TW'(TIMEOUT_CLKS - 1))
        timed_out = 1'b1;
      else
        timer_next = timer_reg + 1'b1;
    end

    if (timed_out) begin
      state_next    = IDLE;
      err_next      = 1'b1;
      err_code_next = 2'b10;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (rx_valid && rx_byte == HEADER) state_next = CMD;
        end
        CMD: begin
          if (rx_valid) begin
            byte_cnt_next = '0;
            if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
              is_rd_next = (rx_byte == CMD_RD);
              state_next = ADDR;
            end else if (rx_byte == CMD_START) begin
              start_next = 1'b1;
              state_next = IDLE;
            end else begin
              err_next      = 1'b1;
              err_code_next = 2'b01;
              state_next    = IDLE;
            end
          end
        end
        ADDR, LEN: begin
          if (rx_valid) begin
            if (state_reg == ADDR) addr_next = (addr_reg << 8) | AW'(rx_byte);
            else count_next = rx_byte;
            if (state_reg == ADDR && byte_cnt_reg != 8'(ADDR_BYTES - 1)) begin
              byte_cnt_next = byte_cnt_reg + 8'd1;
            end else if (state_reg == ADDR && LEN_EN != 0) begin
              byte_cnt_next = '0;
              state_next    = LEN;
            end else begin
              byte_cnt_next = '0;
              if (state_reg == ADDR) count_next = '0;
              if (is_rd_reg) begin
                rd_req_next  = 1'b1;
                rd_addr_next = addr_next;
                state_next   = RD_ISSUE;
              end else begin
                state_next = DATA;
              end
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            word_next = (word_reg << 8) | DW'(rx_byte);
            if (byte_cnt_reg == 8'(DATA_BYTES - 1)) begin
              byte_cnt_next = '0;
              wr_en_next    = 1'b1;
              wr_addr_next  = addr_reg;
              wr_data_next  = word_next;
              addr_next     = addr_reg + 1'b1;
              if (count_reg == 8'd0) state_next = IDLE;
              else count_next = count_reg - 8'd1;
            end else begin
              byte_cnt_next = byte_cnt_reg + 8'd1;
            end
          end
        end
        RD_ISSUE: begin
          if (rx_valid) begin
            err_next      = 1'b1;
            err_code_next = 2'b11;
          end
          if (rd_req_reg && rd_ack) begin
            if (count_reg == 8'd0) begin
              rd_req_next = 1'b0;
              state_next  = IDLE;
            end else begin
              count_next   = count_reg - 8'd1;
              addr_next    = addr_reg + 1'b1;
              rd_addr_next = addr_reg + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign rd_req      = rd_req_reg;
  assign rd_addr     = rd_addr_reg;
  assign start_pulse = start_reg;
  assign err_pulse   = err_reg;
  assign err_code    = err_code_reg;
  assign busy        = busy_reg;

endmodule
